// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the simple-CPU datapath: sequences IF/ID/EX/MEM/WB
// and drives ALU op, mux selects and write enables for add/sub/ori/lw/sw/beq.
module multicycle_ctrl #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] FN_ADD   = 6'b100000,
   parameter logic [5:0] FN_SUB   = 6'b100010,
   parameter logic [5:0] OP_ORI   = 6'b001101,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic [2:0] alu_ctrl,
   output logic       alusrc_imm,
   output logic       ext_sign,
   output logic       reg_dst_rd,
   output logic       mem_to_reg,
   output logic       ir_we,
   output logic       pc_we,
   output logic       pc_branch,
   output logic       reg_we,
   output logic       dmem_re,
   output logic       dmem_we,
   output logic       illegal,
   output logic       instr_done,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      I_ADD, I_SUB, I_ORI, I_LW, I_SW, I_BEQ, I_BAD
   } instr_t;

   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_ORI = 3'b010;
   localparam logic [2:0] ALU_LW  = 3'b110;
   localparam logic [2:0] ALU_SW  = 3'b111;
   localparam logic [2:0] ALU_BEQ = 3'b101;

   function automatic instr_t decode(input logic [5:0] op, input logic [5:0] fn);
      instr_t k;
      k = I_BAD;
      if (op == OP_RTYPE) begin
         if (fn == FN_ADD)      k = I_ADD;
         else if (fn == FN_SUB) k = I_SUB;
      end
      else if (op == OP_ORI) k = I_ORI;
      else if (op == OP_LW)  k = I_LW;
      else if (op == OP_SW)  k = I_SW;
      else if (op == OP_BEQ) k = I_BEQ;
      return k;
   endfunction

   state_t     cur, nxt;
   logic [5:0] opcode_q, funct_q;
   instr_t     id_kind, ex_kind;

   // ID decodes the instruction register directly; later states use the copy
   // captured at the end of ID so the IR is free to change underneath.
   assign id_kind = decode(opcode, funct);
   assign ex_kind = decode(opcode_q, funct_q);
   assign state   = cur;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur      <= S_IF;
         opcode_q <= '0;
         funct_q  <= '0;
      end
      else begin
         cur <= nxt;
         if (cur == S_ID) begin
            opcode_q <= opcode;
            funct_q  <= funct;
         end
      end
   end

   // NOTE: every output and nxt gets a default first, so no path through the
   // case below can leave a signal unassigned and infer a latch.
   always_comb begin
      nxt        = cur;
      alu_ctrl   = 3'b000;
      alusrc_imm = 1'b0;
      ext_sign   = 1'b0;
      reg_dst_rd = 1'b0;
      mem_to_reg = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_branch  = 1'b0;
      reg_we     = 1'b0;
      dmem_re    = 1'b0;
      dmem_we    = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
      // Outputs are held quiet while rst is high so an aborted instruction
      // cannot fire a write enable in the reset cycle.
      if (!rst) begin
         unique case (cur)
            S_IF: begin
               if (imem_ready) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
                  nxt   = S_ID;
               end
            end
            S_ID: begin
               if (id_kind == I_BAD) begin
                  illegal    = 1'b1;
                  instr_done = 1'b1;
                  nxt        = S_IF;
               end
               else begin
                  nxt = S_EX;
               end
            end
            S_EX: begin
               unique case (ex_kind)
                  I_ADD: begin alu_ctrl = ALU_ADD; nxt = S_WB; end
                  I_SUB: begin alu_ctrl = ALU_SUB; nxt = S_WB; end
                  I_ORI: begin
                     alu_ctrl   = ALU_ORI;
                     alusrc_imm = 1'b1;
                     nxt        = S_WB;
                  end
                  I_LW, I_SW: begin
                     alu_ctrl   = (ex_kind == I_LW) ? ALU_LW : ALU_SW;
                     alusrc_imm = 1'b1;
                     ext_sign   = 1'b1;
                     nxt        = S_MEM;
                  end
                  I_BEQ: begin
                     alu_ctrl   = ALU_BEQ;
                     ext_sign   = 1'b1;
                     pc_branch  = zero;
                     instr_done = 1'b1;
                     nxt        = S_IF;
                  end
                  default: nxt = S_IF;
               endcase
            end
            S_MEM: begin
               dmem_re = (ex_kind == I_LW);
               dmem_we = (ex_kind == I_SW);
               if (dmem_ready) begin
                  if (ex_kind == I_LW) begin
                     nxt = S_WB;
                  end
                  else begin
                     instr_done = 1'b1;
                     nxt        = S_IF;
                  end
               end
            end
            S_WB: begin
               reg_we     = 1'b1;
               instr_done = 1'b1;
               mem_to_reg = (ex_kind == I_LW);
               reg_dst_rd = (ex_kind == I_ADD) || (ex_kind == I_SUB);
               nxt        = S_IF;
            end
            default: nxt = S_IF;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction model expands each
// instruction into its expected cycle sequence; one process compares every cycle.
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   typedef enum {K_ADD, K_SUB, K_ORI, K_LW, K_SW, K_BEQ, K_BAD} kind_t;

   typedef struct packed {
      logic [2:0] alu;
      logic imm, sx, rd, m2r, ir_we, pc_we, pc_br, reg_we, re, we, ill, done;
      logic [2:0] st;
   } out_t;

   typedef struct {
      logic       rst, ir, dr, z;
      logic [5:0] op, fn;
      out_t       exp;
      logic       chk_st;
   } cyc_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       zero, imem_ready, dmem_ready;
   logic [2:0] alu_ctrl, state;
   logic       alusrc_imm, ext_sign, reg_dst_rd, mem_to_reg, ir_we, pc_we;
   logic       pc_branch, reg_we, dmem_re, dmem_we, illegal, instr_done;

   cyc_t cyc_q[$];
   out_t cur_exp;
   logic cur_chk_st;
   logic exp_valid = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_ctrl(alu_ctrl),
      .alusrc_imm(alusrc_imm), .ext_sign(ext_sign), .reg_dst_rd(reg_dst_rd),
      .mem_to_reg(mem_to_reg), .ir_we(ir_we), .pc_we(pc_we), .pc_branch(pc_branch),
      .reg_we(reg_we), .dmem_re(dmem_re), .dmem_we(dmem_we), .illegal(illegal),
      .instr_done(instr_done), .state(state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         OP_RTYPE: return (fn == FN_ADD) ? K_ADD : (fn == FN_SUB) ? K_SUB : K_BAD;
         OP_ORI:   return K_ORI;
         OP_LW:    return K_LW;
         OP_SW:    return K_SW;
         OP_BEQ:   return K_BEQ;
         default:  return K_BAD;
      endcase
   endfunction

   function automatic logic [2:0] alu_of(input kind_t k);
      case (k)
         K_ADD:   return 3'b001;
         K_SUB:   return 3'b011;
         K_ORI:   return 3'b010;
         K_LW:    return 3'b110;
         K_SW:    return 3'b111;
         K_BEQ:   return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   // A cycle whose "don't care" inputs are random, so the DUT must ignore them.
   function automatic cyc_t blank();
      cyc_t c;
      c.rst    = 1'b0;
      c.ir     = 1'($urandom);
      c.dr     = 1'($urandom);
      c.z      = 1'($urandom);
      c.op     = 6'($urandom);
      c.fn     = 6'($urandom);
      c.exp    = '0;
      c.chk_st = 1'b1;
      return c;
   endfunction

   task automatic add_reset(input int cycles);
      cyc_t c;
      for (int i = 0; i < cycles; i++) begin
         c        = blank();
         c.rst    = 1'b1;
         c.chk_st = (i > 0);
         cyc_q.push_back(c);
      end
   endtask

   // Expands one instruction into its cycle-by-cycle expectations.
   task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int iw, input int dw, output int n);
      cyc_t  c;
      kind_t k  = classify(op, fn);
      int    n0 = cyc_q.size();
      for (int i = 0; i < iw; i++) begin
         c      = blank();
         c.ir   = 1'b0;
         cyc_q.push_back(c);
      end
      c = blank();
      c.ir = 1'b1;
      c.exp.ir_we = 1'b1;
      c.exp.pc_we = 1'b1;
      cyc_q.push_back(c);
      c = blank();
      c.op = op;
      c.fn = fn;
      c.exp.st = 3'd1;
      if (k == K_BAD) begin
         c.exp.ill  = 1'b1;
         c.exp.done = 1'b1;
         cyc_q.push_back(c);
      end
      else begin
         cyc_q.push_back(c);
         c = blank();
         c.z = z;
         c.exp.st  = 3'd2;
         c.exp.alu = alu_of(k);
         c.exp.imm = (k inside {K_ORI, K_LW, K_SW});
         c.exp.sx  = (k inside {K_LW, K_SW, K_BEQ});
         if (k == K_BEQ) begin
            c.exp.pc_br = z;
            c.exp.done  = 1'b1;
         end
         cyc_q.push_back(c);
         if (k inside {K_LW, K_SW}) begin
            for (int i = 0; i <= dw; i++) begin
               c = blank();
               c.dr = (i == dw);
               c.exp.st   = 3'd3;
               c.exp.re   = (k == K_LW);
               c.exp.we   = (k == K_SW);
               c.exp.done = (i == dw) && (k == K_SW);
               cyc_q.push_back(c);
            end
         end
         if (k inside {K_ADD, K_SUB, K_ORI, K_LW}) begin
            c = blank();
            c.exp.st     = 3'd4;
            c.exp.reg_we = 1'b1;
            c.exp.done   = 1'b1;
            c.exp.m2r    = (k == K_LW);
            c.exp.rd     = (k inside {K_ADD, K_SUB});
            cyc_q.push_back(c);
         end
      end
      n = cyc_q.size() - n0;
   endtask

   always @(negedge clk) begin
      out_t act;
      if (exp_valid) begin
         act = {alu_ctrl, alusrc_imm, ext_sign, reg_dst_rd, mem_to_reg, ir_we, pc_we,
                pc_branch, reg_we, dmem_re, dmem_we, illegal, instr_done, state};
         if (!cur_chk_st) act.st = 3'd0;
         check("cycle_outputs", 32'(act), 32'(cur_exp));
         check("pc_excl", 32'(pc_we & pc_branch), 32'd0);
         check("wr_excl", 32'(reg_we & dmem_we), 32'd0);
      end
   end

   initial begin
      int n;
      int k;
      int idx;
      rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
      imem_ready = 1'b0; dmem_ready = 1'b0;

      add_reset(2);
      add_instr(OP_RTYPE, FN_ADD, 1'b0, 0, 0, n);
      check("lat_add", 32'(n), 32'd4);
      idx = cyc_q.size() - 2;
      check("add_ex_alu", 32'(cyc_q[idx].exp.alu), 32'(3'b001));
      check("add_wb_rd", 32'(cyc_q[idx + 1].exp.rd), 32'd1);
      add_instr(OP_LW, 6'd0, 1'b0, 0, 0, n);
      check("lat_lw", 32'(n), 32'd5);
      add_instr(OP_LW, 6'd0, 1'b0, 0, 2, n);
      check("lat_lw_wait2", 32'(n), 32'd7);
      check("lw_wb_m2r", 32'(cyc_q[cyc_q.size() - 1].exp.m2r), 32'd1);
      add_instr(OP_BEQ, 6'd0, 1'b1, 0, 0, n);
      check("lat_beq", 32'(n), 32'd3);
      check("beq_taken", 32'(cyc_q[cyc_q.size() - 1].exp.pc_br), 32'd1);
      add_instr(OP_BEQ, 6'd0, 1'b0, 1, 0, n);
      check("lat_beq_iwait", 32'(n), 32'd4);
      add_instr(OP_ORI, 6'd0, 1'b0, 0, 0, n);
      idx = cyc_q.size() - 2;
      check("ori_ex_alu", 32'(cyc_q[idx].exp.alu), 32'(3'b010));
      check("ori_ex_sx", 32'(cyc_q[idx].exp.sx), 32'd0);
      add_instr(6'b111111, 6'd0, 1'b0, 0, 0, n);
      check("lat_illegal", 32'(n), 32'd2);
      add_instr(OP_SW, 6'd0, 1'b0, 0, 0, n);
      check("lat_sw", 32'(n), 32'd4);

      // lw aborted by reset while waiting in MEM
      add_instr(OP_LW, 6'd0, 1'b0, 0, 5, n);
      repeat (6) void'(cyc_q.pop_back());
      add_reset(2);
      add_instr(OP_RTYPE, FN_SUB, 1'b0, 0, 0, n);

      for (int i = 0; i < 250; i++) begin
         k = $urandom_range(7, 0);
         case (k)
            0: add_instr(OP_RTYPE, FN_ADD, 1'b0, $urandom_range(2, 0), 0, n);
            1: add_instr(OP_RTYPE, FN_SUB, 1'b0, $urandom_range(2, 0), 0, n);
            2: add_instr(OP_ORI, 6'($urandom), 1'b0, $urandom_range(2, 0), 0, n);
            3: add_instr(OP_LW, 6'($urandom), 1'b0, $urandom_range(2, 0), $urandom_range(3, 0), n);
            4: add_instr(OP_SW, 6'($urandom), 1'b0, $urandom_range(2, 0), $urandom_range(3, 0), n);
            5: add_instr(OP_BEQ, 6'($urandom), 1'($urandom), $urandom_range(2, 0), 0, n);
            6: add_instr(6'($urandom), 6'($urandom), 1'($urandom), $urandom_range(1, 0),
                         $urandom_range(2, 0), n);
            default: add_instr(OP_RTYPE, 6'($urandom), 1'b0, $urandom_range(1, 0), 0, n);
         endcase
         if (i % 60 == 59) add_reset($urandom_range(2, 1));
      end

      foreach (cyc_q[i]) begin
         @(posedge clk);
         #1;
         rst        = cyc_q[i].rst;
         imem_ready = cyc_q[i].ir;
         dmem_ready = cyc_q[i].dr;
         zero       = cyc_q[i].z;
         opcode     = cyc_q[i].op;
         funct      = cyc_q[i].fn;
         cur_exp    = cyc_q[i].exp;
         cur_chk_st = cyc_q[i].chk_st;
         exp_valid  = 1'b1;
      end
      @(posedge clk);
      #1 exp_valid = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
